// File: rtl/scan_sequencer_if.sv
// Control and decoder-drive bundle for scan_sequencer.
// The controller side (master) drives start/stop/mode/mask; the sequencer (slave) drives A/E/busy/done.
interface scan_sequencer_if;
  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] mask;
  logic [1:0] A;
  logic       E;
  logic       busy;
  logic       done;

  modport master (output start, stop, mode, mask, input A, E, busy, done);
  modport slave  (input start, stop, mode, mask, output A, E, busy, done);
endinterface

// File: rtl/scan_sequencer.sv
// Slot scanner driving a 2-to-4 decoder: select A, enable E, with blanking around every select change.
// Supports continuous or single-pass scanning with a live per-slot skip mask.
module scan_sequencer #(
  parameter int DWELL = 8,
  parameter int BLANK = 2,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  scan_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
  // Entry point of every slot: blanking first, or straight into the dwell when BLANK=0.
  localparam logic [1:0] SLOT_STATE = (BLANK > 0) ? S_BLANK : S_DWELL;
  localparam logic       SLOT_E     = (BLANK == 0);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       a_q;
  logic             e_q;
  logic             busy_q;
  logic             done_q;

  logic       any_set;
  logic [1:0] lowest;
  logic [1:0] nxt;
  logic       wrapped;
  logic       lo_found;
  logic       nx_found;
  logic [1:0] cand;

  assign any_set = |bus.mask;

  always_comb begin
    lowest   = '0;
    lo_found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!lo_found && bus.mask[k[1:0]]) begin
        lowest   = k[1:0];
        lo_found = 1'b1;
      end
    end
  end

  // Search upward from A+1, wrapping; k=4 lands back on A so a sole set bit is found last.
  always_comb begin
    nxt      = a_q;
    nx_found = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = a_q + k[1:0];
      if (!nx_found && bus.mask[cand]) begin
        nxt      = cand;
        nx_found = 1'b1;
      end
    end
  end

  assign wrapped = (nxt <= a_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      e_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state  <= S_IDLE;
        cnt    <= '0;
        e_q    <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              if (any_set) begin
                a_q    <= lowest;
                state  <= SLOT_STATE;
                cnt    <= '0;
                e_q    <= SLOT_E;
                busy_q <= 1'b1;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          S_BLANK: begin
            if (cnt == BLANK_LAST) begin
              state <= S_DWELL;
              cnt   <= '0;
              e_q   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DWELL: begin
            if (cnt == DWELL_LAST) begin
              cnt <= '0;
              if (!any_set || (bus.mode && wrapped)) begin
                state  <= S_IDLE;
                e_q    <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                a_q   <= nxt;
                state <= SLOT_STATE;
                e_q   <= SLOT_E;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state  <= S_IDLE;
            cnt    <= '0;
            e_q    <= 1'b0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.A    = a_q;
  assign bus.E    = e_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
